// File: rtl/dilithium_ctrl_if.sv
// Host/core bundle for dilithium_ctrl.
// Purpose: groups the host control/status, host streams, core control and
// core streams of the controller into one interface.
//   slave  : the controller's view (takes host commands, drives the core).
//   master : the environment's view (host plus core model).
// Stream handshake: a beat transfers on any rising clk edge where valid and
// ready are both 1. Valid does not depend on ready. Data is meaningful only
// while valid is 1. A source keeps valid and data stable until the beat
// transfers.
// dbg_state mirrors the controller FSM encoding
// (0 IDLE, 1 LAUNCH, 2 BUSY, 3 DONE, 4 ERR).
interface dilithium_ctrl_if #(
  parameter int W      = 64,
  parameter int CNT_W  = 32,
  parameter int WCNT_W = 16
);
  // host control / status
  logic              start;
  logic [1:0]        mode;
  logic [2:0]        sec_lvl;
  logic              done;
  logic              busy;
  logic [1:0]        err;
  logic [CNT_W-1:0]  cycle_count;
  logic [WCNT_W-1:0] in_count;
  logic [WCNT_W-1:0] out_count;
  // host streams
  logic              valid_i;
  logic              ready_i;
  logic [W-1:0]      data_i;
  logic              valid_o;
  logic              ready_o;
  logic [W-1:0]      data_o;
  // core control
  logic              core_start;
  logic              core_rst;
  logic [1:0]        core_mode;
  logic [2:0]        core_sec_lvl;
  logic              core_done;
  // core streams
  logic              core_valid_i;
  logic              core_ready_i;
  logic [W-1:0]      core_data_i;
  logic              core_valid_o;
  logic              core_ready_o;
  logic [W-1:0]      core_data_o;
  // FSM state observation
  logic [2:0]        dbg_state;

  modport slave (
    input  start, mode, sec_lvl, valid_i, data_i, ready_o,
           core_done, core_ready_i, core_valid_o, core_data_o,
    output done, busy, err, cycle_count, in_count, out_count,
           ready_i, valid_o, data_o,
           core_start, core_rst, core_mode, core_sec_lvl,
           core_valid_i, core_data_i, core_ready_o, dbg_state
  );

  modport master (
    output start, mode, sec_lvl, valid_i, data_i, ready_o,
           core_done, core_ready_i, core_valid_o, core_data_o,
    input  done, busy, err, cycle_count, in_count, out_count,
           ready_i, valid_o, data_o,
           core_start, core_rst, core_mode, core_sec_lvl,
           core_valid_i, core_data_i, core_ready_o, dbg_state
  );
endinterface

// File: rtl/dilithium_ctrl.sv
// dilithium_ctrl: host-side run controller for a Dilithium core.
// Purpose: turns a level start request into a one-cycle core_start, tracks
// the run (IDLE -> LAUNCH -> BUSY -> DONE/ERR), validates mode/sec_lvl,
// runs an optional BUSY watchdog, and gates both data streams so beats only
// move while the core is BUSY.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dilithium_ctrl_if.slave (host control/status, host streams,
//          core control, core streams, dbg_state)
module dilithium_ctrl #(
  parameter int W       = 64,
  parameter int CNT_W   = 32,
  parameter int WCNT_W  = 16,
  parameter int TIMEOUT = 0
) (
  input logic            clk,
  input logic            rst,
  dilithium_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // Last BUSY cycle before the watchdog trips; TIMEOUT-1 sign-extends to
  // all-ones when TIMEOUT is 0, but that case is masked in timeout_hit.
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT - 1);

  state_t            state;
  logic              start_q;
  logic              done_r;
  logic              busy_r;
  logic [1:0]        err_r;
  logic [CNT_W-1:0]  cycle_count;
  logic [WCNT_W-1:0] in_count;
  logic [WCNT_W-1:0] out_count;
  logic              core_start_r;
  logic              core_rst_r;
  logic [1:0]        core_mode_r;
  logic [2:0]        core_sec_lvl_r;

  logic start_edge;
  logic cfg_ok;
  logic en;
  logic timeout_hit;
  logic in_fire;
  logic out_fire;

  assign start_edge  = bus.start & ~start_q;
  assign cfg_ok      = ((bus.sec_lvl == 3'd2) || (bus.sec_lvl == 3'd3) ||
                        (bus.sec_lvl == 3'd5)) && (bus.mode != 2'd3);
  assign en          = (state == S_BUSY);
  assign timeout_hit = (TIMEOUT != 0) && (64'(cycle_count) == TO_LAST);

  // Streams are combinational pass-throughs, opened only while BUSY.
  assign bus.core_valid_i = bus.valid_i & en;
  assign bus.ready_i      = bus.core_ready_i & en;
  assign bus.core_data_i  = bus.data_i[W-1:0];
  assign bus.valid_o      = bus.core_valid_o & en;
  assign bus.core_ready_o = bus.ready_o & en;
  assign bus.data_o       = bus.core_data_o[W-1:0];

  // Counted on the host side of the gates, so they only move in BUSY.
  assign in_fire  = bus.valid_i & bus.ready_i;
  assign out_fire = bus.valid_o & bus.ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      start_q        <= 1'b1;   // start held through reset must not launch
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
      err_r          <= 2'b00;
      cycle_count    <= '0;
      in_count       <= '0;
      out_count      <= '0;
      core_start_r   <= 1'b0;
      core_rst_r     <= 1'b0;
      core_mode_r    <= 2'd0;
      core_sec_lvl_r <= 3'b010;
    end else begin
      start_q      <= bus.start;
      core_start_r <= 1'b0;
      core_rst_r   <= 1'b0;

      if (in_fire && (in_count != '1)) in_count <= in_count + WCNT_W'(1);
      if (out_fire && (out_count != '1)) out_count <= out_count + WCNT_W'(1);

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_edge) begin
            if (cfg_ok) begin
              core_mode_r    <= bus.mode;
              core_sec_lvl_r <= bus.sec_lvl;
              done_r         <= 1'b0;
              err_r          <= 2'b00;
              cycle_count    <= '0;
              in_count       <= '0;
              out_count      <= '0;
              core_start_r   <= 1'b1;
              busy_r         <= 1'b1;
              state          <= S_LAUNCH;
            end else begin
              err_r[0] <= 1'b1;
              done_r   <= 1'b0;
              state    <= S_ERR;
            end
          end
        end
        S_LAUNCH: state <= S_BUSY;
        S_BUSY: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          // core_done wins over a same-cycle watchdog trip
          if (bus.core_done) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_DONE;
          end else if (timeout_hit) begin
            err_r[1]   <= 1'b1;
            core_rst_r <= 1'b1;
            busy_r     <= 1'b0;
            state      <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.done         = done_r;
  assign bus.busy         = busy_r;
  assign bus.err          = err_r;
  assign bus.cycle_count  = cycle_count;
  assign bus.in_count     = in_count;
  assign bus.out_count    = out_count;
  assign bus.core_start   = core_start_r;
  assign bus.core_rst     = core_rst_r;
  assign bus.core_mode    = core_mode_r;
  assign bus.core_sec_lvl = core_sec_lvl_r;
  assign bus.dbg_state    = state;

endmodule

// File: doc/dilithium_ctrl.md
DILITHIUM_CTRL -- requirements
Module: dilithium_ctrl

Interface
REQ-001 SHALL have parameter W, default 64: stream data width.
REQ-002 SHALL have parameter CNT_W, default 32: cycle-counter width.
REQ-003 SHALL have parameter WCNT_W, default 16: word-counter width.
REQ-004 SHALL have parameter TIMEOUT, default 0: BUSY-cycle limit; 0 disables the watchdog.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: start in 1, level request; mode in 2; sec_lvl in 3.
REQ-007 SHALL have host status outputs: done out 1; busy out 1; err out 2 ([0] illegal config, [1] timeout); cycle_count out CNT_W; in_count out WCNT_W; out_count out WCNT_W.
REQ-008 SHALL have host input stream: valid_i in 1; ready_i out 1; data_i in W.
REQ-009 SHALL have host output stream: valid_o out 1; ready_o in 1; data_o out W.
REQ-010 SHALL have core control: core_start out 1; core_rst out 1; core_mode out 2; core_sec_lvl out 3; core_done in 1.
REQ-011 SHALL have core streams: core_valid_i out 1, core_ready_i in 1, core_data_i out W; core_valid_o in 1, core_ready_o out 1, core_data_o in W.

Function
REQ-012 SHALL detect a start rising edge as start=1 with the previous-cycle registered start=0.
REQ-013 SHALL implement states IDLE, LAUNCH, BUSY, DONE, ERR.
REQ-014 SHALL, on an edge in IDLE/DONE/ERR with sec_lvl in {2,3,5} and mode!=3: capture mode/sec_lvl into core_mode/core_sec_lvl, clear done, err, cycle_count, in_count and out_count, and go to LAUNCH next cycle.
REQ-015 SHALL, on an edge with illegal sec_lvl or mode=3: set err[0], clear done, go to ERR, and not assert core_start.
REQ-016 SHALL assert core_start for exactly the one LAUNCH cycle; LAUNCH->BUSY unconditionally.
REQ-017 SHALL ignore start edges in LAUNCH and BUSY.
REQ-018 SHALL, in BUSY, increment cycle_count every cycle, saturating at all-ones; cycle_count is frozen in all other states.
REQ-019 SHALL, on core_done=1 in BUSY, go to DONE; core_done outside BUSY is ignored.
REQ-020 SHALL, with TIMEOUT!=0 and cycle_count==TIMEOUT-1 in BUSY without core_done: go to ERR, set err[1], and pulse core_rst for one cycle.
REQ-021 SHALL give core_done priority over timeout when both occur in the same cycle.
REQ-022 SHALL drive done=1 in DONE, busy=1 in LAUNCH/BUSY, and hold err until the next accepted edge or reset.
REQ-023 SHALL gate streams combinationally, with en=(state==BUSY): core_valid_i=valid_i&en, ready_i=core_ready_i&en, valid_o=core_valid_o&en, core_ready_o=ready_o&en; data passes through unmodified.
REQ-024 SHALL increment in_count on valid_i&ready_i and out_count on valid_o&ready_o, each saturating at all-ones.
REQ-025 SHALL hold core_mode/core_sec_lvl stable from LAUNCH until the next accepted edge.

Reset
REQ-026 SHALL, on rst=1 at a clock edge: state IDLE; done, busy, err, all counters, core_start and core_rst 0; core_mode 0; core_sec_lvl 3'b010.
REQ-027 SHALL reset the previous-start register to 1, so start held high through reset release does not launch.
REQ-028 SHALL, on rst mid-BUSY, abort to IDLE next cycle, with no core_rst pulse (the core is expected to share rst).

Verification
REQ-029 SHALL cover normal run: start 0->1 at cycle N with mode=1, sec_lvl=3 -> core_start=1 only at N+1, core_mode=1, core_sec_lvl=3; core_done at the 10th BUSY cycle -> done=1, cycle_count=10, busy=0.
REQ-030 SHALL cover illegal config: sec_lvl=4 edge -> err=01, done=0, no core_start; then a legal edge -> err=00 and a launch.
REQ-031 SHALL cover timeout: TIMEOUT=8, no core_done -> err=10 after the 8th BUSY cycle, single core_rst pulse, cycle_count=8; with core_done and timeout in the same cycle -> DONE, err=00.
REQ-032 SHALL cover streams: 5 input and 3 output handshakes in BUSY (ready toggling) -> in_count=5, out_count=3; valid_i in IDLE -> ready_i=0, core_valid_i=0, counts unchanged.
REQ-033 SHALL cover start held high across rst release -> stays IDLE; start edge in BUSY -> ignored, cycle_count continues.
REQ-034 SHALL cover saturation: CNT_W=4, 20 BUSY cycles -> cycle_count=15 and held.
